arith_inverse_divider: RTL and testbench

Recovers the pre-multiply sum S = A+B from the output of the team's 3-stage arithmetic unit Y = ((A+B)·C)+D: computes S = (Y − D) / C with remainder, using an iterative restoring divider behind a valid/ready handshake. It sits downstream of that unit in checking and decode paths, for example self-test and result back-annotation. One operation is in flight at a time.

---
 rtl/arith_inv_pkg.sv | 21 ++
 rtl/arith_inverse_divider_seq_div_step.sv | 25 ++
 rtl/arith_inverse_divider.sv | 157 +++++++++++++++
 tb/tb_arith_inverse_divider.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_inv_pkg.sv
// Shared types and constants for the inverse divider of the (A+B)*C+D unit.
// The sum limit is the largest legal A+B for C_W-bit operands.
package arith_inv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DIV,
        DONE
    } arith_inv_state_t;

    localparam int ARITH_Y_W = 18;
    localparam int ARITH_C_W = 8;

    localparam int ARITH_SUM_MAX = 2 * ((1 << ARITH_C_W) - 1);

    function automatic int arith_sum_limit(input int cw);
        return 2 * ((1 << cw) - 1);
    endfunction

endpackage

// File: rtl/arith_inverse_divider_seq_div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract.
// Purely combinational; the top registers the result each cycle.
import arith_inv_pkg::*;

module seq_div_step #(
    parameter int C_W = ARITH_C_W
) (
    input  logic [C_W:0]   rem_in,
    input  logic           bit_in,
    input  logic [C_W-1:0] divisor,
    output logic [C_W:0]   rem_out,
    output logic           q_bit
);

    logic [C_W+1:0] wide;
    logic [C_W+1:0] dvs;

    always_comb begin
        wide    = {rem_in, bit_in};
        dvs     = (C_W+2)'(divisor);
        q_bit   = (wide >= dvs);
        rem_out = q_bit ? (C_W+1)'(wide - dvs) : wide[C_W:0];
    end

endmodule

// File: rtl/arith_inverse_divider.sv
// Recovers S = (Y - D) / C with remainder via an iterative restoring divider.
// Define ARITH_INV_RANGE_CHECK_EN to add the not_sum legality output.
import arith_inv_pkg::*;

module arith_inverse_divider #(
    parameter int Y_W = ARITH_Y_W,
    parameter int C_W = ARITH_C_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [Y_W-1:0] y,
    input  logic [C_W-1:0] c,
    input  logic [C_W-1:0] d,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [Y_W-1:0] quo,
    output logic [C_W-1:0] rem,
    output logic           div_by_zero,
    output logic           underflow,
`ifdef ARITH_INV_RANGE_CHECK_EN
    output logic           not_sum,
`endif
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int CNT_W = $clog2(Y_W + 1);

`ifdef ARITH_INV_RANGE_CHECK_EN
    localparam logic [Y_W-1:0] SUM_LIM = Y_W'(arith_sum_limit(C_W));
`endif

    arith_inv_state_t state;
    arith_inv_state_t state_nxt;

    logic [Y_W-1:0] y_r;
    logic [C_W-1:0] c_r;
    logic [C_W-1:0] d_r;
    logic [Y_W:0]   diff;
    logic           neg;
    logic           c_zero;
    logic           dz_w;
    logic           uf_w;
    logic           err_w;
    logic [C_W:0]   prem;
    logic [Y_W-1:0] qsr;
    logic [CNT_W-1:0] cnt;
    logic [C_W:0]   step_rem;
    logic           step_q;
    logic [Y_W-1:0] q_next;

    seq_div_step #(
        .C_W(C_W)
    ) u_step (
        .rem_in (prem),
        .bit_in (qsr[Y_W-1]),
        .divisor(c_r),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    always_comb begin
        diff   = {1'b0, y_r} - (Y_W+1)'(d_r);
        neg    = diff[Y_W];
        c_zero = (c_r == '0);
        err_w  = dz_w | uf_w;
        q_next = {qsr[Y_W-2:0], step_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = SUB;
            SUB:  state_nxt = DIV;
            DIV:  if (cnt == '0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Errors spend one idle pass through DIV so both paths enter DONE alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r         <= '0;
            c_r         <= '0;
            d_r         <= '0;
            dz_w        <= 1'b0;
            uf_w        <= 1'b0;
            prem        <= '0;
            qsr         <= '0;
            cnt         <= '0;
            quo         <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            underflow   <= 1'b0;
`ifdef ARITH_INV_RANGE_CHECK_EN
            not_sum     <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        y_r <= y;
                        c_r <= c;
                        d_r <= d;
                    end
                end
                SUB: begin
                    dz_w <= c_zero;
                    uf_w <= !c_zero && neg;
                    prem <= '0;
                    if (c_zero || neg) begin
                        qsr <= '0;
                        cnt <= '0;
                    end else begin
                        qsr <= diff[Y_W-1:0];
                        cnt <= CNT_W'(Y_W - 1);
                    end
                end
                DIV: begin
                    if (!err_w) begin
                        prem <= step_rem;
                        qsr  <= q_next;
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        quo         <= err_w ? '0 : q_next;
                        rem         <= err_w ? '0 : step_rem[C_W-1:0];
                        div_by_zero <= dz_w;
                        underflow   <= uf_w;
`ifdef ARITH_INV_RANGE_CHECK_EN
                        not_sum     <= err_w
                                     || (step_rem[C_W-1:0] != '0)
                                     || (q_next > SUM_LIM);
`endif
                    end
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_inverse_divider.sv
// Scoreboard bench for arith_inverse_divider: directed plan cases plus
// randomized traffic checked against an arithmetic reference model.
module tb_arith_inverse_divider;

    localparam int Y_W = 18;
    localparam int C_W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
    logic [C_W-1:0] d;
    logic           in_valid;
    logic           in_ready;
    logic [Y_W-1:0] quo;
    logic [C_W-1:0] rem;
    logic           div_by_zero;
    logic           underflow;
    logic           out_valid;
    logic           out_ready;
`ifdef ARITH_INV_RANGE_CHECK_EN
    logic           not_sum;
`endif

    arith_inverse_divider dut (
        .clk        (clk),
        .rst        (rst),
        .y          (y),
        .c          (c),
        .d          (d),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .quo        (quo),
        .rem        (rem),
        .div_by_zero(div_by_zero),
        .underflow  (underflow),
`ifdef ARITH_INV_RANGE_CHECK_EN
        .not_sum    (not_sum),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int quo;
        int rem;
        bit dz;
        bit uf;
        bit ns;
        int acc;
        int lat;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division of (y - d) by c.
    function automatic exp_t model(input int yy, input int cc, input int dd, input int acc);
        exp_t e;
        e = '{default: 0};
        e.acc = acc;
        if (cc == 0) begin
            e.dz  = 1'b1;
            e.lat = 2;
        end else if (yy < dd) begin
            e.uf  = 1'b1;
            e.lat = 2;
        end else begin
            e.quo = (yy - dd) / cc;
            e.rem = (yy - dd) % cc;
            e.lat = Y_W + 1;
        end
        e.ns = e.dz || e.uf || (e.rem != 0) || (e.quo > 2 * ((1 << C_W) - 1));
        return e;
    endfunction

    function automatic logic [Y_W+C_W+2:0] view();
        logic ns;
        ns = 1'b0;
`ifdef ARITH_INV_RANGE_CHECK_EN
        ns = not_sum;
`endif
        return {quo, rem, div_by_zero, underflow, ns};
    endfunction

    initial begin : monitor
        logic ovp;
        logic [Y_W+C_W+2:0] snap;
        exp_t e;
        ovp = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                if (!ovp) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out_valid: got quo=%0d with no request outstanding", quo);
                    end else begin
                        chk("latency", cyc - sb[0].acc, sb[0].lat);
                    end
                    snap = view();
                end else begin
                    chk("hold_stable", int'(view() !== snap), 0);
                end
                if (out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("quo", int'(quo), e.quo);
                    chk("rem", int'(rem), e.rem);
                    chk("div_by_zero", int'(div_by_zero), int'(e.dz));
                    chk("underflow", int'(underflow), int'(e.uf));
`ifdef ARITH_INV_RANGE_CHECK_EN
                    chk("not_sum", int'(not_sum), int'(e.ns));
`endif
                end
            end
            ovp = out_valid;
        end
    end

    task automatic issue(input int yy, input int cc, input int dd, output int acc);
        bit was;
        y = Y_W'(yy);
        c = C_W'(cc);
        d = C_W'(dd);
        in_valid = 1'b1;
        acc = -1;
        for (int n = 0; n < 200; n++) begin
            was = in_ready;
            @(negedge clk);
            if (was) begin
                acc = cyc;
                break;
            end
        end
        in_valid = 1'b0;
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        end else begin
            sb.push_back(model(yy, cc, dd, acc));
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_quo"}, int'(quo), 0);
        chk({tag, "_rem"}, int'(rem), 0);
        chk({tag, "_div_by_zero"}, int'(div_by_zero), 0);
        chk({tag, "_underflow"}, int'(underflow), 0);
`ifdef ARITH_INV_RANGE_CHECK_EN
        chk({tag, "_not_sum"}, int'(not_sum), 0);
`endif
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int acc;
        int prev;
        int yy;
        int cc;
        int dd;
        bit seen;
        rst = 1'b1;
        in_valid = 1'b0;
        y = '0;
        c = '0;
        d = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(41, 5, 6, acc);
        wait_done();
        issue(130305, 255, 255, acc);
        wait_done();
        issue(130306, 255, 255, acc);
        wait_done();
        issue(100, 0, 3, acc);
        wait_done();
        issue(5, 3, 10, acc);
        wait_done();
        issue(2, 0, 9, acc);
        wait_done();
        issue(262143, 1, 0, acc);
        wait_done();

        out_ready = 1'b0;
        issue(1000, 7, 3, acc);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("bp_reached_done", int'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            y = Y_W'(500 + k);
            c = 8'd3;
            d = 8'd1;
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();

        issue(41, 5, 6, acc);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk_reset_state("midrst");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("midrst_idle", int'(in_ready), 1);
        issue(41, 5, 6, acc);
        wait_done();

        out_ready = 1'b1;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            cc = $urandom_range(1, 255);
            dd = $urandom_range(0, 255);
            yy = $urandom_range(dd, (1 << Y_W) - 1);
            issue(yy, cc, dd, acc);
            if (prev >= 0) chk("b2b_spacing", acc - prev, Y_W + 3);
            prev = acc;
        end
        wait_done();

        for (int i = 0; i < 40; i++) begin
            cc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
            dd = $urandom_range(0, 255);
            yy = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                             : $urandom_range(0, (1 << Y_W) - 1);
            out_ready = $urandom_range(0, 1) == 1;
            issue(yy, cc, dd, acc);
            repeat ($urandom_range(0, 25)) @(negedge clk);
            out_ready = 1'b1;
            wait_done();
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
